// File: rtl/mem_store_buffer_pkg.sv
// mem_store_buffer_pkg: access-size codes, byte-enable constants and lane formatting helpers
package mem_store_buffer_pkg;
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
    localparam logic [3:0] BE_ALL       = 4'b1111;
    localparam int         BE_W         = 4;

    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
        return size == SIZE_BYTE || (size == SIZE_HALF && !off[0]) || (size == SIZE_WORD && off == 2'b00);
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        return size == SIZE_BYTE ? 4'b0001 << off : size == SIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) : BE_ALL;
    endfunction
endpackage

// File: rtl/mem_store_buffer_store_fifo.sv
// store_fifo: circular store queue with per-entry valid bits and a word-address match vector
module store_fifo
    import mem_store_buffer_pkg::*;
#(
    parameter int AW    = 30,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [AW-1:0]    i_addr,
    input  logic [DW-1:0]    i_data,
    input  logic [BE_W-1:0]  i_be,
    input  logic [AW-1:0]    i_cmp_addr,
    output logic [AW-1:0]    o_addr,
    output logic [DW-1:0]    o_data,
    output logic [BE_W-1:0]  o_be,
    output logic [DEPTH-1:0] o_match,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]   addr_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [BE_W-1:0] be_q   [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (i_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
        end
    end

    // payload needs no reset: valid bits gate every use of it
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            addr_q[wr_ptr] <= i_addr;
            data_q[wr_ptr] <= i_data;
            be_q[wr_ptr]   <= i_be;
        end
    end

    always_comb begin
        o_match = '0;
        for (int k = 0; k < DEPTH; k++) o_match[k] = valid[k] && addr_q[k] == i_cmp_addr;
    end

    assign o_addr  = addr_q[rd_ptr];
    assign o_data  = data_q[rd_ptr];
    assign o_be    = be_q[rd_ptr];
    assign o_empty = count == '0;
    assign o_full  = count == (PW+1)'(DEPTH);
endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: MEM-stage store path; formats sb/sh/sw, buffers them and drains
// into data memory on cycles the port is free of loads, stalling on full or load hazards.
module mem_store_buffer
    import mem_store_buffer_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter int DEPTH  = 4,
    parameter int MEM_AW = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_memwrite,
    input  logic              i_memread,
    input  logic [NBITS-1:0]  i_address,
    input  logic [NBITS-1:0]  i_storedata,
    input  logic [1:0]        i_size,
    output logic              o_stall,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [NBITS-1:0]  o_mem_wdata,
    output logic [BE_W-1:0]   o_mem_be,
    output logic              o_empty,
    output logic              o_error
);
    localparam int AW = NBITS - 2;

    logic             legal, full, hazard, push, pop;
    logic [NBITS-1:0] fmt_data;
    logic [AW-1:0]    head_addr;
    logic [DEPTH-1:0] match;

    assign legal    = is_legal(i_size, i_address[1:0]);
    assign fmt_data = i_size == SIZE_BYTE ? {4{i_storedata[7:0]}} :
                      i_size == SIZE_HALF ? {2{i_storedata[15:0]}} : i_storedata;
    assign hazard   = i_memread && |match;
    assign push     = i_memwrite && legal && !full;
    // a pending store to the loaded word must be flushed before the load may proceed
    assign pop      = !o_empty && (!i_memread || hazard);
    assign o_stall  = (i_memwrite && legal && full) || hazard;

    store_fifo #(.AW(AW), .DW(NBITS), .DEPTH(DEPTH)) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (push),
        .i_pop      (pop),
        .i_addr     (i_address[NBITS-1:2]),
        .i_data     (fmt_data),
        .i_be       (lane_be(i_size, i_address[1:0])),
        .i_cmp_addr (i_address[NBITS-1:2]),
        .o_addr     (head_addr),
        .o_data     (o_mem_wdata),
        .o_be       (o_mem_be),
        .o_match    (match),
        .o_empty    (o_empty),
        .o_full     (full)
    );

    assign o_mem_we   = pop;
    assign o_mem_addr = head_addr[MEM_AW-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) o_error <= 1'b0;
        else if (i_memwrite && (!legal || i_memread)) o_error <= 1'b1;
    end
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: directed scenarios plus random traffic checked each cycle
// against a queue-based model of the store buffer.
module tb_mem_store_buffer;
    logic        i_clk = 0, i_reset = 0, i_memwrite = 0, i_memread = 0;
    logic [31:0] i_address = 0, i_storedata = 0;
    logic [1:0]  i_size = 0;
    logic        o_stall, o_mem_we, o_empty, o_error;
    logic [9:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;

    mem_store_buffer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_memwrite(i_memwrite), .i_memread(i_memread),
        .i_address(i_address), .i_storedata(i_storedata), .i_size(i_size),
        .o_stall(o_stall), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .o_empty(o_empty), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {logic [29:0] wa; logic [31:0] d; logic [3:0] be;} ent_t;
    ent_t q[$];
    ent_t e_new;
    bit   m_err, e_pop, e_push, e_errset, chk_on;
    int   n_vec = 0, n_err = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rs, input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] sd, input logic [1:0] sz);
        int  off;
        bit  legal, hit, full, stall;
        @(negedge i_clk);
        i_reset = rs; i_memwrite = w; i_memread = r; i_address = a; i_storedata = sd; i_size = sz;
        #1;
        off   = a % 4;
        legal = sz == 0 || (sz == 1 && off % 2 == 0) || (sz == 2 && off == 0);
        hit   = 0;
        foreach (q[i]) if (q[i].wa == a[31:2]) hit = 1;
        full     = q.size() == 4;
        stall    = (w && legal && full) || (r && hit);
        e_pop    = q.size() != 0 && (!r || hit);
        e_push   = w && legal && !full;
        e_errset = w && (!legal || r);
        e_new.wa = a[31:2];
        e_new.be = sz == 0 ? 4'(1 << off) : sz == 1 ? (off >= 2 ? 4'hC : 4'h3) : 4'hF;
        e_new.d  = sz == 0 ? {4{sd[7:0]}} : sz == 1 ? {2{sd[15:0]}} : sd;
        if (chk_on) begin
            chk("stall", o_stall, stall);
            chk("we", o_mem_we, e_pop);
            chk("empty", o_empty, q.size() == 0);
            chk("error", o_error, m_err);
            if (e_pop) begin
                chk("addr", o_mem_addr, q[0].wa[9:0]);
                chk("wdata", o_mem_wdata, q[0].d);
                chk("be", o_mem_be, q[0].be);
            end
        end
    endtask

    task automatic commit();
        @(posedge i_clk);
        if (i_reset) begin
            q.delete();
            m_err = 0;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_push) q.push_back(e_new);
            if (e_errset) m_err = 1;
        end
    endtask

    task automatic cyc(input bit rs, input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] sd, input logic [1:0] sz);
        drive(rs, w, r, a, sd, sz);
        commit();
    endtask

    initial begin
        chk_on = 0;
        cyc(1, 0, 0, 0, 0, 0);
        chk_on = 1;
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_empty", o_empty, 1); chk("rst_stall", o_stall, 0);
        chk("rst_we", o_mem_we, 0); chk("rst_error", o_error, 0);
        commit();
        // single word store drains the following cycle
        cyc(0, 1, 0, 32'h10, 32'hDEADBEEF, 2);
        drive(0, 0, 0, 0, 0, 0);
        chk("sw_we", o_mem_we, 1); chk("sw_addr", o_mem_addr, 4);
        chk("sw_be", o_mem_be, 4'hF); chk("sw_wdata", o_mem_wdata, 32'hDEADBEEF);
        commit();
        drive(0, 0, 0, 0, 0, 0);
        chk("sw_empty", o_empty, 1);
        commit();
        // byte then half, in order
        cyc(0, 1, 0, 32'h13, 32'h000000A5, 0);
        drive(0, 1, 0, 32'h16, 32'h00001234, 1);
        chk("sb_be", o_mem_be, 4'h8); chk("sb_wdata", o_mem_wdata, 32'hA5A5A5A5);
        commit();
        drive(0, 0, 0, 0, 0, 0);
        chk("sh_be", o_mem_be, 4'hC); chk("sh_wdata", o_mem_wdata, 32'h12341234);
        commit();
        // fill while the port is held by loads
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 32'h100 + 4 * i, i, 2);
        drive(0, 1, 1, 32'h200, 5, 2);
        chk("full_stall", o_stall, 1);
        commit();
        repeat (4) cyc(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("drained", o_empty, 1);
        commit();
        cyc(1, 0, 0, 0, 0, 0);
        // load-after-store hazard
        cyc(0, 1, 0, 32'h20, 32'h55, 2);
        drive(0, 0, 1, 32'h20, 0, 2);
        chk("haz_stall", o_stall, 1); chk("haz_we", o_mem_we, 1); chk("haz_addr", o_mem_addr, 8);
        commit();
        drive(0, 0, 1, 32'h20, 0, 2);
        chk("haz_clear", o_stall, 0);
        commit();
        // misaligned half
        drive(0, 1, 0, 32'h11, 32'h77, 1);
        chk("mis_stall", o_stall, 0);
        commit();
        drive(0, 0, 0, 0, 0, 0);
        chk("mis_error", o_error, 1); chk("mis_empty", o_empty, 1);
        commit();
        // reset discards queued stores
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h40 + 4 * i, i, 2);
        cyc(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst2_empty", o_empty, 1); chk("rst2_error", o_error, 0); chk("rst2_we", o_mem_we, 0);
        commit();
        // random traffic over a small address window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            bit          rs, w, r;
            logic [31:0] a, sd;
            logic [1:0]  sz;
            rs = $urandom_range(0, 199) == 0;
            w  = $urandom_range(0, 1);
            r  = $urandom_range(0, 2) != 0;
            a  = $urandom_range(0, 63);
            sd = $urandom;
            sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            cyc(rs, w, r, a, sd, sz);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
